// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for the 3-input gate bank: walks all 8 input vectors and grades the 7 outputs.
// A full run takes 8*(SETTLE+2) busy cycles plus one FINISH cycle; START is ignored while not idle.
module gate_bist_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_out_and,
    input  logic       i_out_or,
    input  logic       i_out_nand,
    input  logic       i_out_nor,
    input  logic       i_out_not,
    input  logic       i_out_buf,
    input  logic       i_out_exor,
    output logic       o_in_1,
    output logic       o_in_2,
    output logic       o_in_3,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_cnt,
    output logic [2:0] o_fail_vec,
    output logic [6:0] o_fail_mask
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t     r_state;
    logic [2:0] r_vec;
    logic [3:0] r_settle;
    logic [2:0] r_in;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_cnt;
    logic [2:0] r_fail_vec;
    logic [6:0] r_fail_mask;

    logic [6:0] w_expected;
    logic [6:0] w_actual;
    logic [6:0] w_mismatch;
    logic       w_fail;
    logic [3:0] w_err_next;

    // Bit order of both vectors: [0]AND [1]OR [2]NAND [3]NOR [4]NOT [5]BUF [6]EXOR
    assign w_expected = {r_vec[0] ^ r_vec[1],
                         r_vec[0],
                         ~r_vec[0],
                         ~(r_vec[0] | r_vec[1]),
                         ~(r_vec[0] & r_vec[1]),
                         |r_vec,
                         r_vec[0] & r_vec[1]};
    assign w_actual   = {i_out_exor, i_out_buf, i_out_not, i_out_nor,
                         i_out_nand, i_out_or, i_out_and};
    assign w_mismatch = w_actual ^ w_expected;
    assign w_fail     = |w_mismatch;
    assign w_err_next = r_err_cnt + {3'b000, w_fail};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_vec       <= 3'd0;
            r_settle    <= 4'd0;
            r_in        <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= 4'd0;
            r_fail_vec  <= 3'd0;
            r_fail_mask <= 7'd0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && r_busy) begin
                // Abort keeps partial results but never reports a verdict.
                r_state <= S_IDLE;
                r_in    <= 3'd0;
                r_busy  <= 1'b0;
                r_pass  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_abort) begin
                            r_state     <= S_APPLY;
                            r_vec       <= 3'd0;
                            r_in        <= 3'd0;
                            r_busy      <= 1'b1;
                            r_pass      <= 1'b0;
                            r_err_cnt   <= 4'd0;
                            r_fail_vec  <= 3'd0;
                            r_fail_mask <= 7'd0;
                        end
                    end
                    S_APPLY: begin
                        r_settle <= LP_SETTLE;
                        r_state  <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (r_settle <= 4'd1) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_settle <= r_settle - 4'd1;
                        end
                    end
                    S_CHECK: begin
                        r_err_cnt <= w_err_next;
                        if (w_fail && (r_err_cnt == 4'd0)) begin
                            r_fail_vec  <= r_vec;
                            r_fail_mask <= w_mismatch;
                        end
                        if (r_vec == 3'd7) begin
                            r_state <= S_FINISH;
                            r_in    <= 3'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 4'd0);
                        end else begin
                            r_state <= S_APPLY;
                            r_vec   <= r_vec + 3'd1;
                            r_in    <= r_vec + 3'd1;
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_in    <= 3'd0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_in_1      = r_in[0];
    assign o_in_2      = r_in[1];
    assign o_in_3      = r_in[2];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_cnt   = r_err_cnt;
    assign o_fail_vec  = r_fail_vec;
    assign o_fail_mask = r_fail_mask;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: two instances (SETTLE=2 and SETTLE=1) each driving a faultable gate-bank model.
module tb_gate_bist_ctrl;

    logic            clk;
    logic            rst_n;
    logic [1:0]      start;
    logic [1:0]      abort;
    logic [1:0]      busy;
    logic [1:0]      done;
    logic [1:0]      pass;
    logic [1:0][2:0] inb;
    logic [1:0][3:0] err;
    logic [1:0][2:0] fv;
    logic [1:0][6:0] fm;
    logic [1:0][6:0] bank;
    logic [1:0][6:0] sa0;
    logic [1:0][6:0] sa1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         inst;
        int         done_cyc;
        logic [3:0] err;
        logic [2:0] fv;
        logic [6:0] fm;
        logic       pass;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference gate bank: output bit order AND, OR, NAND, NOR, NOT, BUF, EXOR.
    function automatic logic [6:0] good_out(input logic [2:0] v);
        int a, b, c, s;
        logic [6:0] g;
        a = int'(v[0]);
        b = int'(v[1]);
        c = int'(v[2]);
        s = a + b;
        g[0] = (s == 2);
        g[1] = (s + c > 0);
        g[2] = (s != 2);
        g[3] = (s == 0);
        g[4] = (a == 0);
        g[5] = (a == 1);
        g[6] = (s == 1);
        return g;
    endfunction

    function automatic logic [6:0] bank_fn(input logic [2:0] v, input logic [6:0] s0, input logic [6:0] s1);
        return (good_out(v) & ~s0) | s1;
    endfunction

    // Results the controller should hold after grading vectors 0..nvec-1.
    function automatic exp_t model(input logic [6:0] s0, input logic [6:0] s1, input int nvec);
        exp_t e;
        logic [6:0] mis;
        e.inst = 0; e.done_cyc = 0; e.err = 0; e.fv = 0; e.fm = 0;
        for (int v = 0; v < nvec; v++) begin
            mis = bank_fn(3'(v), s0, s1) ^ good_out(3'(v));
            if (mis != 7'd0) begin
                if (e.err == 0) begin
                    e.fv = 3'(v);
                    e.fm = mis;
                end
                e.err = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    assign bank[0] = bank_fn(inb[0], sa0[0], sa1[0]);
    assign bank[1] = bank_fn(inb[1], sa0[1], sa1[1]);

    gate_bist_ctrl #(.SETTLE(2)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
        .i_out_and(bank[0][0]), .i_out_or(bank[0][1]), .i_out_nand(bank[0][2]),
        .i_out_nor(bank[0][3]), .i_out_not(bank[0][4]), .i_out_buf(bank[0][5]),
        .i_out_exor(bank[0][6]),
        .o_in_1(inb[0][0]), .o_in_2(inb[0][1]), .o_in_3(inb[0][2]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
        .o_err_cnt(err[0]), .o_fail_vec(fv[0]), .o_fail_mask(fm[0])
    );

    gate_bist_ctrl #(.SETTLE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
        .i_out_and(bank[1][0]), .i_out_or(bank[1][1]), .i_out_nand(bank[1][2]),
        .i_out_nor(bank[1][3]), .i_out_not(bank[1][4]), .i_out_buf(bank[1][5]),
        .i_out_exor(bank[1][6]),
        .o_in_1(inb[1][0]), .o_in_2(inb[1][1]), .o_in_3(inb[1][2]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
        .o_err_cnt(err[1]), .o_fail_vec(fv[1]), .o_fail_mask(fm[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every DONE pulse retires the oldest expected run result.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst=%0d actual=1 required=0 (cycle %0d)", i, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("done_inst", i, mon_e.inst);
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    chk("err_cnt", err[i], mon_e.err);
                    chk("fail_vec", fv[i], mon_e.fv);
                    chk("fail_mask", fm[i], mon_e.fm);
                    chk("pass", pass[i], mon_e.pass);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    function automatic int period(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    // Launches one run; optionally re-pulses START mid-run and in FINISH, and checks BUSY/IN bus per cycle.
    task automatic run(input int i, input logic [6:0] s0, input logic [6:0] s1,
                       input bit repulse, input bit chk_bus);
        exp_t e;
        int per, last;
        per  = period(i);
        last = 8 * per + 1;
        sa0[i] = s0;
        sa1[i] = s1;
        e = model(s0, s1, 8);
        e.inst = i;
        e.done_cyc = cyc + last;
        q.push_back(e);
        start[i] = 1'b1;
        for (int r = 1; r <= last; r++) begin
            tick();
            start[i] = repulse && (r == 5 || r == 20 || r == last);
            if (chk_bus) begin
                chk("busy_in_run", busy[i], (r < last) ? 1 : 0);
                chk("in_bus", inb[i], (r < last) ? (r - 1) / per : 0);
            end
        end
        tick();
        start[i] = 1'b0;
        if (repulse) chk("busy_after_finish_start", busy[i], 0);
        wait_q();
    endtask

    initial begin
        exp_t pe;
        rst_n = 1'b0;
        start = '0;
        abort = '0;
        sa0   = '0;
        sa1   = '0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_pass", pass[i], 0);
            chk("rst_err", err[i], 0);
            chk("rst_fv", fv[i], 0);
            chk("rst_fm", fm[i], 0);
            chk("rst_in", inb[i], 0);
        end
        rst_n = 1'b1;
        tick();

        run(0, 7'b0000000, 7'b0000000, 1'b0, 1'b1);
        run(0, 7'b1000000, 7'b0000000, 1'b0, 1'b0);
        run(0, 7'b0010000, 7'b0000010, 1'b0, 1'b0);

        // Abort in the WAIT of vector 3 with EXOR stuck low.
        sa0[0] = 7'b1000000;
        sa1[0] = 7'b0000000;
        pe = model(sa0[0], sa1[0], 3);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (13) tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort_busy", busy[0], 0);
        chk("abort_in", inb[0], 0);
        chk("abort_pass", pass[0], 0);
        chk("abort_done", done[0], 0);
        chk("abort_err", err[0], pe.err);
        chk("abort_fv", fv[0], pe.fv);
        chk("abort_fm", fm[0], pe.fm);
        repeat (40) tick();
        run(0, 7'b0000000, 7'b0000000, 1'b0, 1'b0);

        run(0, 7'($urandom), 7'($urandom) & 7'($urandom), 1'b1, 1'b1);

        // START and ABORT together in IDLE start nothing.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("start_abort_busy", busy[0], 0);
        repeat (40) tick();
        chk("start_abort_idle", busy[0], 0);

        // Asynchronous reset during the CHECK of vector 5.
        sa0[0] = 7'b1000000;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (23) tick();
        chk("pre_rst_busy", busy[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy[0], 0);
        chk("arst_err", err[0], 0);
        chk("arst_fv", fv[0], 0);
        chk("arst_fm", fm[0], 0);
        chk("arst_in", inb[0], 0);
        chk("arst_pass", pass[0], 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", busy[0], 0);

        run(1, 7'b0000000, 7'b0000000, 1'b0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            run(k % 2, 7'($urandom), 7'($urandom) & 7'($urandom), (k % 3) == 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
